// File: rtl/iram_access_arbiter_pkg.sv
// Shared types and constants for the instruction-RAM access arbiter.
// Holds the FSM state encoding, the default RAM address width and the counter load helper.
package iram_access_arbiter_pkg;

  localparam int IRAM_ADR_W = 12;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } arb_state_e;

  // A phase of N cycles is counted from N-1 down to the zero flag.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/iram_access_arbiter_down_counter.sv
// Loadable 4-bit down-counter with a zero flag; decrements saturate at zero.
// Used by the arbiter to time the drain and hold phases.
module arb_down_counter
  import iram_access_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iram_access_arbiter.sv
// Shares the instruction RAM between CPU fetch and the debug monitor: freezes and drains
// fetch, steers the RAM ports to the monitor, then releases fetch with sequenced stall strobes.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | fetch owns the RAM; monitor requests and start pulses sampled
// DRAIN   | stall held while the fetch pipeline empties
// ACCESS  | monitor address/write data driven onto the RAM
// CAPTURE | read data captured, mon_ack pulsed
// HOLD    | grant kept open for back-to-back monitor accesses
// RELEASE | stall dropped, fetch regains the RAM next cycle
module iram_access_arbiter
  import iram_access_arbiter_pkg::*;
#(
  parameter int ADR_W        = IRAM_ADR_W,
  parameter int DRAIN_CYCLES = 2,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_run,
  input  logic             mon_req,
  input  logic             mon_we,
  input  logic [ADR_W-1:0] mon_adr,
  input  logic [31:0]      mon_wdata,
  output logic             mon_ack,
  output logic [31:0]      mon_rdata,
  input  logic             cpu_start_in,
  output logic             cpu_start_out,
  input  logic [31:0]      i_ram_rdata,
  output logic             i_read_sel,
  output logic [ADR_W-1:0] i_ram_radr,
  output logic [ADR_W-1:0] i_ram_wadr,
  output logic [31:0]      i_ram_wdata,
  output logic             i_ram_wen,
  output logic             stall,
  output logic             stall_1shot,
  output logic             stall_dly,
  output logic             busy
);

  arb_state_e  state_q, state_d;
  logic        drain_load, drain_dec, drain_zero;
  logic        hold_load, hold_dec, hold_zero;
  logic        stall_q, stall_d;
  logic        stall_1shot_q, stall_dly_q;
  logic [31:0] rdata_q;
  logic        start_pending_q, start_out_q;
  logic        start_fwd, start_issue;
  logic        in_access, capture_rd;

  arb_down_counter u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (cnt_load(DRAIN_CYCLES)),
    .dec      (drain_dec),
    .zero     (drain_zero)
  );

  arb_down_counter u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (cnt_load(HOLD_CYCLES)),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    stall_d    = stall_q;
    case (state_q)
      ST_IDLE: begin
        if (mon_req) begin
          state_d    = cpu_run ? ST_DRAIN : ST_ACCESS;
          drain_load = cpu_run;
        end
        stall_d = mon_req & cpu_run;
      end
      ST_DRAIN: begin
        if (drain_zero) begin
          state_d = ST_ACCESS;
        end else begin
          drain_dec = 1'b1;
        end
      end
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d   = ST_HOLD;
        hold_load = 1'b1;
      end
      // A request in the same cycle the hold count expires still wins the RAM.
      ST_HOLD: begin
        if (mon_req) begin
          state_d = ST_ACCESS;
        end else if (hold_zero) begin
          state_d = ST_RELEASE;
          stall_d = 1'b0;
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  assign in_access  = (state_q == ST_ACCESS);
  assign capture_rd = (state_q == ST_CAPTURE) && !mon_we;

  // Start pulses are forwarded straight through only when the RAM is not being claimed.
  assign start_fwd   = (state_q == ST_IDLE) && !mon_req;
  assign start_issue = (state_q == ST_RELEASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q         <= 1'b0;
      stall_1shot_q   <= 1'b0;
      stall_dly_q     <= 1'b0;
      rdata_q         <= '0;
      start_pending_q <= 1'b0;
      start_out_q     <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      stall_1shot_q <= (state_q == ST_IDLE) && mon_req && cpu_run;
      stall_dly_q   <= stall_q;
      if (capture_rd) begin
        rdata_q <= i_ram_rdata;
      end
      start_out_q <= (start_fwd & cpu_start_in) |
                     (start_issue & (start_pending_q | cpu_start_in));
      if (start_issue) begin
        start_pending_q <= 1'b0;
      end else if (cpu_start_in && !start_fwd) begin
        start_pending_q <= 1'b1;
      end
    end
  end

  // Read data is passed through in the ack cycle so it is valid alongside mon_ack.
  assign mon_rdata     = capture_rd ? i_ram_rdata : rdata_q;
  assign mon_ack       = (state_q == ST_CAPTURE);
  assign busy          = (state_q != ST_IDLE);
  assign i_read_sel    = (state_q == ST_ACCESS) || (state_q == ST_CAPTURE) || (state_q == ST_HOLD);
  assign i_ram_radr    = i_read_sel ? mon_adr : '0;
  assign i_ram_wadr    = in_access ? mon_adr : '0;
  assign i_ram_wdata   = in_access ? mon_wdata : '0;
  assign i_ram_wen     = in_access & mon_we;
  assign stall         = stall_q;
  assign stall_1shot   = stall_1shot_q;
  assign stall_dly     = stall_dly_q;
  assign cpu_start_out = start_out_q;

endmodule

// File: tb/tb_iram_access_arbiter.sv
// Directed bench for iram_access_arbiter with a behavioural RAM and an expected-ack scoreboard.
// Cycle numbers count rising clock edges; outputs are sampled on the falling edge.
module tb_iram_access_arbiter;

  localparam int ADR_W = 12;
  localparam int DRAIN = 2;
  localparam int HOLD  = 8;

  logic             clk;
  logic             rst;
  logic             cpu_run;
  logic             mon_req;
  logic             mon_we;
  logic [ADR_W-1:0] mon_adr;
  logic [31:0]      mon_wdata;
  logic             mon_ack;
  logic [31:0]      mon_rdata;
  logic             cpu_start_in;
  logic             cpu_start_out;
  logic [31:0]      ram_rdata;
  logic             i_read_sel;
  logic [ADR_W-1:0] i_ram_radr;
  logic [ADR_W-1:0] i_ram_wadr;
  logic [31:0]      i_ram_wdata;
  logic             i_ram_wen;
  logic             stall;
  logic             stall_1shot;
  logic             stall_dly;
  logic             busy;

  iram_access_arbiter #(
    .ADR_W        (ADR_W),
    .DRAIN_CYCLES (DRAIN),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_run       (cpu_run),
    .mon_req       (mon_req),
    .mon_we        (mon_we),
    .mon_adr       (mon_adr),
    .mon_wdata     (mon_wdata),
    .mon_ack       (mon_ack),
    .mon_rdata     (mon_rdata),
    .cpu_start_in  (cpu_start_in),
    .cpu_start_out (cpu_start_out),
    .i_ram_rdata   (ram_rdata),
    .i_read_sel    (i_read_sel),
    .i_ram_radr    (i_ram_radr),
    .i_ram_wadr    (i_ram_wadr),
    .i_ram_wdata   (i_ram_wdata),
    .i_ram_wen     (i_ram_wen),
    .stall         (stall),
    .stall_1shot   (stall_1shot),
    .stall_dly     (stall_dly),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations return a known per-address pattern.
  function automatic logic [31:0] init_word(input logic [ADR_W-1:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  logic [31:0] mem [int];
  always @(posedge clk) begin : ram_model
    logic [31:0] rd;
    rd = mem.exists(int'(i_ram_radr)) ? mem[int'(i_ram_radr)] : init_word(i_ram_radr);
    if (i_ram_wen) mem[int'(i_ram_wadr)] = i_ram_wdata;
    ram_rdata <= rd;
  end

  int               n_1shot = 0, n_fall = 0, n_stall_hi = 0, n_wen = 0, n_start = 0, n_ack = 0;
  int               last_start_cyc = 0;
  logic [ADR_W-1:0] last_wadr = '0;
  logic             stall_prev = 1'b0;
  always @(negedge clk) begin
    stall_prev <= stall;
    if (stall_1shot) n_1shot <= n_1shot + 1;
    if (stall_prev && !stall) n_fall <= n_fall + 1;
    if (stall) n_stall_hi <= n_stall_hi + 1;
    if (i_ram_wen) begin
      n_wen     <= n_wen + 1;
      last_wadr <= i_ram_wadr;
    end
    if (cpu_start_out) begin
      n_start        <= n_start + 1;
      last_start_cyc <= cyc;
    end
    if (mon_ack) n_ack <= n_ack + 1;
  end

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_start(input bit we, input logic [ADR_W-1:0] adr, input logic [31:0] wd,
                           input int lat, input logic [31:0] exp_data, input bit track);
    exp_t e;
    mon_req   = 1'b1;
    mon_we    = we;
    mon_adr   = adr;
    mon_wdata = wd;
    if (track) begin
      e.is_read = !we;
      e.data    = exp_data;
      e.due     = cyc + lat;
      sb.push_back(e);
    end
  endtask

  // Waits for mon_ack, retires the oldest expectation, and returns one cycle past the ack.
  task automatic wait_ack(output int ack_cyc);
    bit   got;
    int   i;
    exp_t e;
    got = 0;
    i = 0;
    ack_cyc = -1;
    while (!got && i < 60) begin
      @(negedge clk);
      i++;
      if (mon_ack === 1'b1) begin
        got = 1;
        ack_cyc = cyc;
      end
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check("ack_unexpected", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ack_cycle", 32'(ack_cyc), 32'(e.due));
      if (e.is_read) check("rdata", mon_rdata, e.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    @(negedge clk);
    while (busy !== 1'b0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int a, a2, a3, s0, f0, w0, h0, k0;
    rst = 1'b1;
    cpu_run = 1'b0;
    mon_req = 1'b0;
    mon_we = 1'b0;
    mon_adr = '0;
    mon_wdata = '0;
    cpu_start_in = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(mon_ack), 32'd0);
    check("rst_rdata", mon_rdata, 32'd0);
    check("rst_wen", 32'(i_ram_wen), 32'd0);
    check("rst_start", 32'(cpu_start_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Drained read with cpu running.
    cpu_run = 1'b1;
    tick();
    req_start(1'b0, 12'h010, 32'h0, DRAIN + 2, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t1_stall_req_cycle", 32'(stall), 32'd0);
    @(negedge clk);
    check("t1_stall_rise", 32'(stall), 32'd1);
    check("t1_1shot_first", 32'(stall_1shot), 32'd1);
    @(negedge clk);
    check("t1_1shot_second", 32'(stall_1shot), 32'd0);
    check("t1_stall_held", 32'(stall), 32'd1);
    wait_ack(a);
    mon_req = 1'b0;
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      check("t1_stall_hold", 32'(stall), 32'd1);
    end
    @(negedge clk);
    check("t1_release_stall", 32'(stall), 32'd0);
    check("t1_release_dly", 32'(stall_dly), 32'd1);
    check("t1_release_sel", 32'(i_read_sel), 32'd0);
    check("t1_release_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_dly", 32'(stall_dly), 32'd0);
    check("t1_rdata_kept", mon_rdata, 32'hDEADBEEF);

    // Write with cpu halted, then read it back.
    tick();
    cpu_run = 1'b0;
    w0 = n_wen;
    h0 = n_stall_hi;
    req_start(1'b1, 12'hFFF, 32'h12345678, 2, 32'h0, 1'b1);
    wait_ack(a);
    mon_req = 1'b0;
    check("t2_rdata_not_overwritten", mon_rdata, 32'hDEADBEEF);
    wait_idle();
    tick();
    check("t2_wen_pulses", 32'(n_wen - w0), 32'd1);
    check("t2_wadr", 32'(last_wadr), 32'h00000FFF);
    req_start(1'b0, 12'hFFF, 32'h0, 2, 32'h12345678, 1'b1);
    wait_ack(a);
    mon_req = 1'b0;
    wait_idle();
    tick();
    check("t2_no_stall", 32'(n_stall_hi - h0), 32'd0);

    // Three back-to-back reads.
    cpu_run = 1'b1;
    tick();
    s0 = n_1shot;
    f0 = n_fall;
    req_start(1'b0, 12'h020, 32'h0, DRAIN + 2, init_word(12'h020), 1'b1);
    wait_ack(a);
    req_start(1'b0, 12'h021, 32'h0, 2, init_word(12'h021), 1'b1);
    wait_ack(a2);
    req_start(1'b0, 12'h022, 32'h0, 2, init_word(12'h022), 1'b1);
    wait_ack(a3);
    mon_req = 1'b0;
    check("t3_gap_1_2", 32'(a2 - a), 32'd3);
    check("t3_gap_2_3", 32'(a3 - a2), 32'd3);
    check("t3_no_fall", 32'(n_fall - f0), 32'd0);
    check("t3_one_1shot", 32'(n_1shot - s0), 32'd1);
    wait_idle();
    tick();
    check("t3_one_fall", 32'(n_fall - f0), 32'd1);

    // Start pulse in IDLE is forwarded next cycle.
    cpu_start_in = 1'b1;
    tick();
    cpu_start_in = 1'b0;
    @(negedge clk);
    check("t4_start_forward", 32'(cpu_start_out), 32'd1);
    tick();

    // Start pulse during HOLD is deferred to the first IDLE cycle.
    k0 = n_start;
    req_start(1'b0, 12'h040, 32'h0, DRAIN + 2, init_word(12'h040), 1'b1);
    wait_ack(a);
    mon_req = 1'b0;
    tick();
    cpu_start_in = 1'b1;
    tick();
    cpu_start_in = 1'b0;
    @(negedge clk);
    check("t4_start_held", 32'(cpu_start_out), 32'd0);
    wait_idle();
    tick();
    tick();
    check("t4_start_count", 32'(n_start - k0), 32'd1);
    check("t4_start_cycle", 32'(last_start_cyc), 32'(a + HOLD + 2));

    // Reset in the middle of DRAIN.
    tick();
    req_start(1'b0, 12'h050, 32'h0, 0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_stall_before_rst", 32'(stall), 32'd1);
    k0 = n_ack;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_1shot", 32'(stall_1shot), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_sel", 32'(i_read_sel), 32'd0);
    mon_req = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_ack", 32'(n_ack - k0), 32'd0);
    check("t5_rdata_cleared", mon_rdata, 32'd0);
    req_start(1'b0, 12'h030, 32'h0, DRAIN + 2, init_word(12'h030), 1'b1);
    wait_ack(a);
    mon_req = 1'b0;
    wait_idle();

    // Request on the last HOLD cycle keeps the grant.
    tick();
    req_start(1'b0, 12'h060, 32'h0, DRAIN + 2, init_word(12'h060), 1'b1);
    wait_ack(a);
    mon_req = 1'b0;
    f0 = n_fall;
    for (int i = 0; i < HOLD - 1; i++) tick();
    req_start(1'b0, 12'h061, 32'h0, 2, init_word(12'h061), 1'b1);
    wait_ack(a2);
    mon_req = 1'b0;
    check("t6_ack_cycle", 32'(a2 - a), 32'(HOLD + 2));
    check("t6_no_fall", 32'(n_fall - f0), 32'd0);
    check("t6_stall_kept", 32'(stall), 32'd1);
    wait_idle();
    tick();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iram_access_arbiter.md
Name: iram_access_arbiter

Overview:
- Shares the single-port-read instruction RAM between CPU fetch and the debug monitor (UART loader/dumper).
- On a monitor request it freezes the fetch stage, drains it, and steers the RAM address/write ports to the monitor.
- It returns read data with a fixed latency, then releases the CPU with correctly sequenced stall strobes.
- Sits between the monitor block and the fetch stage. It drives the fetch stage's i_read_sel, i_ram_* and stall-family inputs.

Parameters:
- ADR_W, 12: instruction RAM word-address width (byte address bits [13:2]).
- DRAIN_CYCLES, 2: cycles the stall is held before the first monitor access. Legal range 1..15.
- HOLD_CYCLES, 8: idle cycles the grant is kept open for back-to-back monitor accesses before release. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_run  in  1  CPU is executing; when 0, no stall sequencing is needed
- mon_req  in  1  monitor access request (level)
- mon_we  in  1  1 = write, 0 = read; valid with mon_req
- mon_adr  in  ADR_W  word address
- mon_wdata  in  32  write data
- mon_ack  out  1  one-cycle completion pulse
- mon_rdata  out  32  captured read data; valid from the mon_ack cycle until the next capture
- cpu_start_in  in  1  start pulse from the monitor
- cpu_start_out  out  1  start pulse forwarded to fetch
- i_ram_rdata  in  32  RAM read data (1-cycle synchronous read)
- i_read_sel  out  1  selects the monitor address onto the RAM read port
- i_ram_radr  out  ADR_W  read address
- i_ram_wadr  out  ADR_W  write address
- i_ram_wdata  out  32  write data
- i_ram_wen  out  1  write enable
- stall  out  1  freeze the fetch PC
- stall_1shot  out  1  first stall cycle only
- stall_dly  out  1  stall delayed by one cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, mon_rdata = 0, FSM = IDLE, counters = 0, start_pending = 0.
- Handshake:
  - The requester holds mon_req, mon_we, mon_adr and mon_wdata stable until mon_ack.
  - It drops mon_req the cycle after mon_ack.
  - mon_req is only sampled in IDLE and HOLD.
- FSM states: IDLE, DRAIN, ACCESS, CAPTURE, HOLD, RELEASE.
- IDLE:
  - mon_req & cpu_run -> DRAIN. stall=1 and stall_1shot=1 in the first DRAIN cycle; drain counter loads DRAIN_CYCLES-1.
  - mon_req & ~cpu_run -> ACCESS directly; stall stays 0.
- DRAIN: stall=1. Counter decrements; at 0 -> ACCESS.
- ACCESS (one cycle):
  - i_read_sel=1, i_ram_radr = i_ram_wadr = mon_adr.
  - i_ram_wen = mon_we, i_ram_wdata = mon_wdata.
  - Next state CAPTURE.
- CAPTURE (one cycle):
  - If read, mon_rdata <= i_ram_rdata.
  - mon_ack=1 for both reads and writes, giving a uniform latency of ACCESS+1.
  - Hold counter loads HOLD_CYCLES-1.
  - -> HOLD.
- HOLD:
  - stall stays as entered; i_read_sel=1.
  - mon_req -> ACCESS; this is the back-to-back path, with no extra drain.
  - Otherwise the counter decrements; at 0 -> RELEASE.
  - A request arriving in the same cycle the counter hits 0 wins and goes to ACCESS.
- RELEASE (one cycle):
  - stall=0, i_read_sel=0, stall_dly=1.
  - -> IDLE. mon_req in RELEASE is ignored until IDLE.
- stall_dly: registered copy of stall, in all states.
- Latency:
  - cpu_run=1: first ack on cycle DRAIN_CYCLES+2 after req sampled.
  - cpu_run=0: first ack on cycle 2.
  - Back-to-back: ack 2 cycles after req in HOLD.
- cpu_run dropping while busy: no effect on the current sequence; stall is still released via RELEASE.
- cpu_start_in:
  - In IDLE with no mon_req: forwarded as cpu_start_out on the next cycle.
  - Otherwise latched into start_pending and issued in the first IDLE cycle after RELEASE.
  - A second start while pending is merged.
- i_ram_wen is never asserted outside ACCESS.
- Asynchronous rst mid-operation returns everything to the reset values immediately. A pending ack is lost.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit enum: IDLE, DRAIN, ACCESS, CAPTURE, HOLD, RELEASE).
  - IRAM_ADR_W = 12 constant.
- One natural sub-module: arb_down_counter (4-bit loadable down-counter with zero flag), instantiated twice for drain and hold.

Test Plan:
- cpu_run=1, DRAIN_CYCLES=2, read adr 0x010 holding 0xDEADBEEF:
  - stall rises the cycle after req, stall_1shot for exactly 1 cycle.
  - mon_ack at cycle 4 with mon_rdata=0xDEADBEEF.
  - stall falls 8 cycles after ack; stall_dly is high 1 cycle after.
- cpu_run=0, write adr 0xFFF data 0x12345678:
  - stall never asserts.
  - i_ram_wen high exactly 1 cycle with wadr 0xFFF.
  - Ack at cycle 2; a follow-up read returns 0x12345678.
- Three back-to-back reads, each issued 1 cycle after the previous ack:
  - Acks 3 cycles apart.
  - stall stays continuously high; no second stall_1shot.
- cpu_start_in pulsed during HOLD:
  - No cpu_start_out until after RELEASE.
  - Exactly one cpu_start_out pulse in the first IDLE cycle.
- rst asserted during DRAIN: all outputs 0 immediately, no ack; a new request after reset completes normally.
- mon_req arriving exactly as the hold counter reaches 0: goes to ACCESS, no RELEASE, stall not dropped.
